// File: rtl/input_port_pkg.sv
// Shared constants and types for the button/switch input port register window.
package input_port_pkg;

    typedef logic [1:0] rd_addr_t;

    localparam int DATA_W = 32;

    localparam rd_addr_t ADDR_SW      = 2'd0;
    localparam rd_addr_t ADDR_BTN     = 2'd1;
    localparam rd_addr_t ADDR_BTN_EVT = 2'd2;
    localparam rd_addr_t ADDR_SW_EVT  = 2'd3;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and accepted (stable) level.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Any return to the accepted level restarts the count, so short glitches never land.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_switch_input_port.sv
// Debounced switch/button input port with a 4-word read-only window and sticky button events.
// Define INPUT_PORT_SW_EVENT_EN to add sticky switch-change events at word 3 (also drives irq).
module button_switch_input_port
    import input_port_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic              rd_en,
    input  rd_addr_t          rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    logic [NUM_SW-1:0]  w_sw_stable;
    logic [NUM_BTN-1:0] w_btn_stable;
    logic [NUM_BTN-1:0] r_btn_stable_d;
    logic [NUM_BTN-1:0] w_btn_rise;
    logic [NUM_BTN-1:0] w_btn_clr;
    logic [NUM_BTN-1:0] r_btn_evt;
    logic [NUM_SW-1:0]  w_sw_evt_word;
    logic               w_sw_evt_any;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_irq;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk    (clk),
            .i_rst    (reset),
            .i_raw    (sw_raw[g]),
            .o_stable (w_sw_stable[g])
        );
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk    (clk),
            .i_rst    (reset),
            .i_raw    (btn_raw[g]),
            .o_stable (w_btn_stable[g])
        );
    end

    assign w_btn_rise = w_btn_stable & ~r_btn_stable_d;
    assign w_btn_clr  = (rd_en && rd_addr == ADDR_BTN_EVT) ? r_btn_evt : '0;

    // Clear only what this read returns; a rise in the same cycle re-sets the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_stable_d <= '0;
            r_btn_evt      <= '0;
        end else begin
            r_btn_stable_d <= w_btn_stable;
            r_btn_evt      <= (r_btn_evt & ~w_btn_clr) | w_btn_rise;
        end
    end

`ifdef INPUT_PORT_SW_EVENT_EN
    logic [NUM_SW-1:0] r_sw_stable_d;
    logic [NUM_SW-1:0] r_sw_evt;
    logic [NUM_SW-1:0] w_sw_change;
    logic [NUM_SW-1:0] w_sw_clr;

    assign w_sw_change = w_sw_stable ^ r_sw_stable_d;
    assign w_sw_clr    = (rd_en && rd_addr == ADDR_SW_EVT) ? r_sw_evt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_stable_d <= '0;
            r_sw_evt      <= '0;
        end else begin
            r_sw_stable_d <= w_sw_stable;
            r_sw_evt      <= (r_sw_evt & ~w_sw_clr) | w_sw_change;
        end
    end

    assign w_sw_evt_word = r_sw_evt;
    assign w_sw_evt_any  = |r_sw_evt;
`else
    assign w_sw_evt_word = '0;
    assign w_sw_evt_any  = 1'b0;
`endif

    always_comb begin
        w_rd_word = '0;
        case (rd_addr)
            ADDR_SW:      w_rd_word[NUM_SW-1:0]  = w_sw_stable;
            ADDR_BTN:     w_rd_word[NUM_BTN-1:0] = w_btn_stable;
            ADDR_BTN_EVT: w_rd_word[NUM_BTN-1:0] = r_btn_evt;
            ADDR_SW_EVT:  w_rd_word[NUM_SW-1:0]  = w_sw_evt_word;
            default:      w_rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
            r_irq <= (|r_btn_evt) | w_sw_evt_any;
        end
    end

    assign rd_data = r_rd_data;
    assign irq     = r_irq;

endmodule

// File: doc/button_switch_input_port.md
Name: button_switch_input_port

Overview:
- Input-side peripheral that carries board state into the processor. It is the counterpart of the display/LED output path.
- Synchronises and debounces the slide switches and push buttons.
- Latches button-press events in a sticky register.
- Exposes everything as a 4-word read-only register window with one-cycle read latency and read-to-clear on the event word.
- Sits beside the seven-segment subsystem in the top level, on the processor clock domain.

Parameters:
NUM_SW, 16, number of slide switches (1..32)
NUM_BTN, 5, number of push buttons (1..32)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a bit is accepted (10 ms at 25 MHz); minimum 2

Ports:
clk  input  1  processor clock
reset  input  1  asynchronous, active-high reset
sw_raw  input  NUM_SW  raw switch pins, asynchronous
btn_raw  input  NUM_BTN  raw button pins, asynchronous, 1 = pressed
rd_en  input  1  read strobe, one cycle per access
rd_addr  input  2  word address of the read
rd_data  output  32  read data, registered
irq  output  1  high while any button event bit is set

Behaviour:
- Reset (asynchronous, active-high): synchroniser flops, debounce counters, stable bits, event bits, rd_data and irq all go to 0.
- Synchroniser: two flops per input bit. Total pin-to-sync delay is 2 cycles.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES):
  - sync == stable: counter <= 0.
  - otherwise: counter increments.
  - On the cycle counter == DEBOUNCE_CYCLES-1 with sync != stable: stable <= sync, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and never changes stable.
- Button event: when a button's stable bit rises 0->1, its event bit is set on the next edge. Falling edges generate no event.
- Register map (unused upper bits read 0):
  - addr 0: debounced switches, zero-extended.
  - addr 1: debounced button levels, zero-extended.
  - addr 2: button event bits, sticky.
  - addr 3: reserved, reads 0 (see Optional Feature).
- Read timing:
  - rd_en sampled at edge N; rd_data valid from edge N+1 and holds until the next rd_en.
  - rd_en low: rd_data holds its last value.
- Read-to-clear:
  - A read of addr 2 clears exactly the bits returned in that rd_data.
  - If a new event for the same bit arrives in the same cycle as the clear, set wins and the bit stays 1.
- irq: registered OR of the event bits. It is high the cycle after the first event is set and low the cycle after the clear takes effect.
- Reset asserted mid-debounce or mid-read: everything is cleared immediately. A partial count is discarded.
- Back-to-back reads on consecutive cycles are legal. Each returns the state as of its own sampling edge.

Optional Feature:
- Macro: INPUT_PORT_SW_EVENT_EN.
- Defined:
  - Any change (either direction) of a debounced switch sets a sticky bit in a switch-event register at addr 3, read-to-clear with the same set-wins rule.
  - irq becomes the OR of button events and switch events.
- Undefined: addr 3 reads 0, no switch-event storage is instantiated, and irq reflects button events only.

Decomposition:
- Package input_port_pkg:
  - DATA_W = 32.
  - Address constants ADDR_SW = 2'd0, ADDR_BTN = 2'd1, ADDR_BTN_EVT = 2'd2, ADDR_SW_EVT = 2'd3.
  - typedef rd_addr_t (logic [1:0]).
- Sub-module debounce_bit:
  - Contains the 2-flop synchroniser, the counter and the stable flop for one bit, with parameter DEBOUNCE_CYCLES.
  - Generate-instantiated NUM_SW + NUM_BTN times.
  - Output is the stable level only; edge and event logic stays in the top of the block.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Reset: assert reset with sw_raw=16'hFFFF; rd_data=0 and irq=0 immediately. After release, read addr 0 -> 32'h0000_FFFF once 2 + 4 cycles have elapsed.
2. Glitch rejection: pulse btn_raw[0] high for 3 cycles -> addr 1 and addr 2 read 0, irq stays 0. Hold it for 6 cycles -> addr 1 reads 32'h1.
3. Event and clear: debounced press of btn[2] -> irq=1 and addr 2 reads 32'h4. A second read of addr 2 returns 0, and irq drops the cycle after the first read.
4. Set-wins collision: time btn[1]'s stable rise to the same cycle as an addr 2 read returning 32'h4 -> that read returns 32'h4, the next read returns 32'h2, and irq stays 1 throughout.
5. Read latency and addr 3: rd_en with addr 0 then addr 3 on consecutive cycles -> rd_data equals the switch word at N+1 and 0 at N+2 (macro undefined). With INPUT_PORT_SW_EVENT_EN defined, toggling sw[5] yields 32'h20 at addr 3.
6. Mid-debounce reset: assert reset while the btn[3] counter = 2 -> after release with the pin still high, the full 4 stable cycles are needed before addr 1 bit 3 sets.
